pipe_stage_reg: RTL

//  Generic elastic pipeline register for the pipelined CPU. It replaces the fixed per-stage latches (D->E, E->M, M->W)

---
 rtl/pipe_stage_reg.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Elastic pipeline register that sits between two CPU pipeline stages.
//   The upstream side hands over entries with ValidD/ReadyD and the
//   downstream side takes them with ValidE/ReadyE. Entries leave in the
//   order they arrived. The control payload reads as zero whenever the
//   stage is empty, so a bubble can never trigger a write further down.
//
//   SKID=1 : two entries (main + skid). ReadyD comes straight from a flop,
//            so there is no path from ReadyE to ReadyD.
//   SKID=0 : one entry. ReadyD = ~ValidE | ReadyE (combinational).
//
// Ports
//   CLK        clock, all state changes on the rising edge
//   CLR        synchronous active-high reset; wins over FLUSH and transfers
//   FLUSH      synchronous kill of every held entry; wins over transfers
//   ValidD     upstream entry valid
//   ReadyD     stage accepts an entry this cycle
//   CtrlD      upstream control payload  [CTRL_W]
//   DataD      upstream data payload     [DATA_W]
//   ValidE     downstream entry valid
//   ReadyE     downstream takes the entry this cycle (0 = stall)
//   CtrlE      control payload, all zeros while ValidE=0
//   DataE      data payload, keeps its last value while ValidE=0
//   Occupancy  number of held entries (0..2)
//   StallCnt   saturating count of cycles with ValidE=1 and ReadyE=0
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              FLUSH,
    input  logic              ValidD,
    output logic              ReadyD,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [DATA_W-1:0] DataD,
    output logic              ValidE,
    input  logic              ReadyE,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [DATA_W-1:0] DataE,
    output logic [1:0]        Occupancy,
    output logic [CNT_W-1:0]  StallCnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Main (output) register, shared by both modes.
    logic              valid_reg;
    logic [CTRL_W-1:0] ctrl_reg;
    logic [DATA_W-1:0] data_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic              take_out;

    assign take_out = valid_reg & ReadyE;

    assign ValidE   = valid_reg;
    assign CtrlE    = ctrl_reg;
    assign DataE    = data_reg;
    assign StallCnt = stall_cnt_reg;

    // Stall counter: only CLR clears it; a flush leaves it untouched.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            stall_cnt_reg <= '0;
        end else if (valid_reg && !ReadyE && !(&stall_cnt_reg)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            state_t            state_reg;
            logic              ready_reg;
            logic [CTRL_W-1:0] skid_ctrl_reg;
            logic [DATA_W-1:0] skid_data_reg;
            logic              take_in;

            assign take_in   = ValidD & ready_reg;
            assign ReadyD    = ready_reg;
            assign Occupancy = state_reg;

            // ready_reg is kept equal to (state != TWO) for the next state,
            // which keeps ReadyE out of the ReadyD cone.
            always_ff @(posedge CLK) begin
                if (CLR) begin
                    state_reg     <= ST_EMPTY;
                    ready_reg     <= 1'b1;
                    valid_reg     <= 1'b0;
                    ctrl_reg      <= '0;
                    data_reg      <= '0;
                    skid_ctrl_reg <= '0;
                    skid_data_reg <= '0;
                end else if (FLUSH) begin
                    // Anything accepted or leaving on this edge is simply dropped.
                    state_reg     <= ST_EMPTY;
                    ready_reg     <= 1'b1;
                    valid_reg     <= 1'b0;
                    ctrl_reg      <= '0;
                    skid_ctrl_reg <= '0;
                end else begin
                    case (state_reg)
                        ST_EMPTY: begin
                            if (take_in) begin
                                state_reg <= ST_ONE;
                                valid_reg <= 1'b1;
                                ctrl_reg  <= CtrlD;
                                data_reg  <= DataD;
                            end
                        end
                        ST_ONE: begin
                            if (take_in && take_out) begin
                                ctrl_reg <= CtrlD;
                                data_reg <= DataD;
                            end else if (take_in) begin
                                state_reg     <= ST_TWO;
                                ready_reg     <= 1'b0;
                                skid_ctrl_reg <= CtrlD;
                                skid_data_reg <= DataD;
                            end else if (take_out) begin
                                state_reg <= ST_EMPTY;
                                valid_reg <= 1'b0;
                                ctrl_reg  <= '0;
                            end
                        end
                        ST_TWO: begin
                            if (take_out) begin
                                state_reg     <= ST_ONE;
                                ready_reg     <= 1'b1;
                                ctrl_reg      <= skid_ctrl_reg;
                                data_reg      <= skid_data_reg;
                                skid_ctrl_reg <= '0;
                            end
                        end
                        default: begin
                            state_reg <= ST_EMPTY;
                            ready_reg <= 1'b1;
                            valid_reg <= 1'b0;
                            ctrl_reg  <= '0;
                        end
                    endcase
                end
            end
        end else begin : g_noskid
            logic ready_comb;

            assign ready_comb = ~valid_reg | ReadyE;
            assign ReadyD     = ready_comb;
            assign Occupancy  = {1'b0, valid_reg};

            // Loads on every ReadyD cycle; a bubble clears the control
            // payload but leaves the data payload where it was.
            always_ff @(posedge CLK) begin
                if (CLR) begin
                    valid_reg <= 1'b0;
                    ctrl_reg  <= '0;
                    data_reg  <= '0;
                end else if (FLUSH) begin
                    valid_reg <= 1'b0;
                    ctrl_reg  <= '0;
                end else if (ready_comb) begin
                    valid_reg <= ValidD;
                    ctrl_reg  <= ValidD ? CtrlD : '0;
                    if (ValidD) begin
                        data_reg <= DataD;
                    end
                end
            end
        end
    endgenerate

endmodule
